ms_es_dsc_mul_gen: RTL and testbench

Parametrised deterministic stochastic-computing (DSC) multiplier. Each operand is expanded into a unary stream that is STRIDE lanes wide. The streams from the NUM_INPUTS operands are ANDed across all STRIDE^NUM_INPUTS lane combinations, and a parallel counter accumulates the result back to binary. All sequence-number generators sit in the single `clk` domain and advance as an odometer using carry enables, with no ripple clocks. The block sits in the arch-sweep datapath as the generalised replacement for the fixed stride-2 ordered multipliers, and adds a start/busy/done handshake and a run-length counter.

---
 rtl/ms_es_dsc_mul_gen.sv | 165 ++++++++++++++++
 tb/tb_ms_es_dsc_mul_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ms_es_dsc_mul_gen.sv
// Deterministic stochastic-computing multiplier; optional early exit via MS_ES_DSC_MUL_EARLY_TERM_EN.
// Latency: start + R RUN cycles + 1 DONE cycle, R = (2^W/S)^N or shorter with early exit.
// Backpressure: none; start is only honoured in IDLE and ignored while busy or in DONE.
module ms_es_dsc_mul_gen #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int STRIDE     = 2,
  parameter int OUT_WIDTH  = DATA_WIDTH * NUM_INPUTS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] bin_data_in,
  output logic                                  busy,
  output logic                                  done,
  output logic [OUT_WIDTH-1:0]                  bin_data_out,
  output logic [15:0]                           cycles_out
);

  localparam int SW    = $clog2(STRIDE);
  localparam int CW    = DATA_WIDTH - SW;
  localparam int CWE   = (CW > 0) ? CW : 1;
  localparam int XW    = DATA_WIDTH + 1;
  localparam int LANES = STRIDE ** NUM_INPUTS;
  localparam int PW    = $clog2(LANES + 1);
  localparam logic [CWE-1:0] CMAX = CWE'((1 << CW) - 1);

  if (NUM_INPUTS < 2 || NUM_INPUTS > 5 || (1 << SW) != STRIDE ||
      STRIDE > (1 << DATA_WIDTH) || LANES > 64) begin : g_bad_cfg
    $error("ms_es_dsc_mul_gen: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                                state;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] sorted;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] x_q;
  logic [NUM_INPUTS-1:0][CWE-1:0]        cnt;
  logic [NUM_INPUTS:0]                   carry;
  logic [NUM_INPUTS-1:0][STRIDE-1:0]     lane;
  logic [LANES-1:0]                      prod;
  logic [PW-1:0]                         pop;
  logic [OUT_WIDTH-1:0]                  acc;
  logic [OUT_WIDTH-1:0]                  acc_next;
  logic [15:0]                           run_cnt;
  logic [15:0]                           run_next;
  logic                                  overflow;
  logic                                  finish;

  // Bubble-style compare-and-swap network: descending order, x[0] largest.
  always_comb begin
    logic [DATA_WIDTH-1:0] tmp;
    tmp    = '0;
    sorted = bin_data_in;
    for (int p = 0; p < NUM_INPUTS - 1; p++) begin
      for (int q = 0; q < NUM_INPUTS - 1 - p; q++) begin
        if (sorted[q] < sorted[q+1]) begin
          tmp         = sorted[q];
          sorted[q]   = sorted[q+1];
          sorted[q+1] = tmp;
        end
      end
    end
  end

  // Odometer carry chain: digit i steps only when every faster digit is at max.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_carry
    assign carry[i+1] = carry[i] & (cnt[i] == CMAX);
  end
  assign overflow = carry[NUM_INPUTS];

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    logic [XW-1:0] base;
    assign base = XW'(cnt[i]) << SW;
    for (genvar k = 0; k < STRIDE; k++) begin : g_bit
      assign lane[i][k] = {1'b0, x_q[i]} > (base + XW'(k));
    end
  end

  // Operand 0 selects the most significant base-S digit of the product lane index.
  for (genvar j = 0; j < LANES; j++) begin : g_prod
    logic [NUM_INPUTS-1:0] terms;
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_term
      localparam int D = (j / (STRIDE ** (NUM_INPUTS - 1 - i))) % STRIDE;
      assign terms[i] = lane[i][D];
    end
    assign prod[j] = &terms;
  end

  always_comb begin
    pop = '0;
    for (int j = 0; j < LANES; j++) begin
      pop = pop + PW'(prod[j]);
    end
  end

  assign acc_next = acc + OUT_WIDTH'(pop);
  assign run_next = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;

`ifdef MS_ES_DSC_MUL_EARLY_TERM_EN
  // Lanes are monotone in k, so lane 0 clear means the smallest operand is exhausted.
  logic early;
  assign early  = ~lane[NUM_INPUTS-1][0];
  assign finish = overflow | early;
`else
  assign finish = overflow;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      bin_data_out <= '0;
      cycles_out   <= '0;
      x_q          <= '0;
      cnt          <= '0;
      acc          <= '0;
      run_cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_q     <= sorted;
            cnt     <= '0;
            acc     <= '0;
            run_cnt <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          acc     <= acc_next;
          run_cnt <= run_next;
          for (int i = 0; i < NUM_INPUTS; i++) begin
            if (carry[i]) begin
              cnt[i] <= (cnt[i] == CMAX) ? '0 : cnt[i] + CWE'(1);
            end
          end
          // Outputs are loaded on the way out so they are already valid in DONE.
          if (finish) begin
            busy         <= 1'b0;
            done         <= 1'b1;
            bin_data_out <= acc_next;
            cycles_out   <= run_next;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ms_es_dsc_mul_gen.sv
// Directed bench for ms_es_dsc_mul_gen: a W=5/N=2/S=2 instance and a W=4/N=3/S=4 instance.
`timescale 1ns/1ps
module tb_ms_es_dsc_mul_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            start_a, start_b;
  logic [1:0][4:0] din_a;
  logic [2:0][3:0] din_b;
  logic            busy_a, done_a, busy_b, done_b;
  logic [9:0]      out_a;
  logic [11:0]     out_b;
  logic [15:0]     cyc_a, cyc_b;
  int              n_cmp = 0;
  int              n_err = 0;
  int              pulses;

`ifdef MS_ES_DSC_MUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  ms_es_dsc_mul_gen #(.DATA_WIDTH(5), .NUM_INPUTS(2), .STRIDE(2)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .start        (start_a),
    .bin_data_in  (din_a),
    .busy         (busy_a),
    .done         (done_a),
    .bin_data_out (out_a),
    .cycles_out   (cyc_a)
  );

  ms_es_dsc_mul_gen #(.DATA_WIDTH(4), .NUM_INPUTS(3), .STRIDE(4)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .start        (start_b),
    .bin_data_in  (din_b),
    .busy         (busy_b),
    .done         (done_b),
    .bin_data_out (out_b),
    .cycles_out   (cyc_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of RUN cycle 1.
  task automatic issue_a(input logic [4:0] a, input logic [4:0] b);
    din_a[0] = a;
    din_a[1] = b;
    start_a  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a  = 1'b0;
  endtask

  task automatic issue_b(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    din_b[0] = a;
    din_b[1] = b;
    din_b[2] = c;
    start_b  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b  = 1'b0;
  endtask

  // n0 is the cycle number (start edge = cycle 0) of the current negedge.
  task automatic await_done(input bit sel, input string tag, input int n0,
                            input int exp_res, input int exp_cyc);
    int n;
    n = n0;
    while ((sel ? done_b : done_a) !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/done_cycle"}, 64'(n), 64'(exp_cyc + 1));
    chk({tag, "/result"}, sel ? 64'(out_b) : 64'(out_a), 64'(exp_res));
    chk({tag, "/cycles"}, sel ? 64'(cyc_b) : 64'(cyc_a), 64'(exp_cyc));
  endtask

  // One cycle after done: pulse gone, not busy, result held.
  task automatic post_done(input bit sel, input string tag, input int exp_res);
    @(negedge clk);
    chk({tag, "/done_pulse"}, sel ? 64'(done_b) : 64'(done_a), 64'd0);
    chk({tag, "/idle_busy"}, sel ? 64'(busy_b) : 64'(busy_a), 64'd0);
    chk({tag, "/held"}, sel ? 64'(out_b) : 64'(out_a), 64'(exp_res));
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    din_a   = '0;
    din_b   = '0;
    repeat (3) @(negedge clk);
    chk("rst/busy", 64'(busy_a), 64'd0);
    chk("rst/done", 64'(done_a), 64'd0);
    chk("rst/out", 64'(out_a), 64'd0);
    chk("rst/cycles", 64'(cyc_a), 64'd0);
    chk("rst/b_out", 64'(out_b), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 13 x 7
    issue_a(5'd13, 5'd7);
    chk("t1/busy", 64'(busy_a), 64'd1);
    await_done(1'b0, "t1", 1, 91, ET ? 65 : 256);
    post_done(1'b0, "t1", 91);

    // 31 x 31: last stripe has lane 1 zero but lane 0 set, no early exit
    issue_a(5'd31, 5'd31);
    await_done(1'b0, "t2", 1, 961, 256);
    post_done(1'b0, "t2", 961);

    // zero operand
    issue_a(5'd0, 5'd31);
    await_done(1'b0, "t3", 1, 0, ET ? 1 : 256);
    post_done(1'b0, "t3", 0);

    // three unsorted operands, S=4
    issue_b(4'd3, 4'd15, 4'd10);
    chk("t4/busy", 64'(busy_b), 64'd1);
    await_done(1'b1, "t4", 1, 450, ET ? 17 : 64);
    post_done(1'b1, "t4", 450);

    // start during RUN is ignored
    issue_a(5'd13, 5'd7);
    repeat (4) @(negedge clk);
    din_a[0] = 5'd31;
    din_a[1] = 5'd31;
    start_a  = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
    await_done(1'b0, "t5", 6, 91, ET ? 65 : 256);
    post_done(1'b0, "t5", 91);

    // reset at RUN cycle 10
    issue_a(5'd31, 5'd31);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6/busy", 64'(busy_a), 64'd0);
    chk("t6/done", 64'(done_a), 64'd0);
    chk("t6/out", 64'(out_a), 64'd0);
    chk("t6/cycles", 64'(cyc_a), 64'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (300) begin
      @(negedge clk);
      if (done_a === 1'b1) pulses++;
    end
    chk("t6/no_done", 64'(pulses), 64'd0);

    // recovery after reset
    issue_a(5'd13, 5'd7);
    await_done(1'b0, "t7", 1, 91, ET ? 65 : 256);
    post_done(1'b0, "t7", 91);

    // back-to-back: second start in the IDLE cycle right after DONE
    issue_a(5'd31, 5'd31);
    await_done(1'b0, "t8a", 1, 961, 256);
    post_done(1'b0, "t8a", 961);
    issue_a(5'd7, 5'd13);
    chk("t8/accepted", 64'(busy_a), 64'd1);
    repeat (20) @(negedge clk);
    chk("t8/old_held", 64'(out_a), 64'd961);
    await_done(1'b0, "t8b", 21, 91, ET ? 65 : 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
